// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one smux1 full-adder cell reused LSB-first, one bit per clock.
// Optional signed-overflow output is built when SERIAL_ADD_OVF_EN is defined.
module smux1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_co;
    logic             last, accept;

    smux1 u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start_valid && (state == IDLE);

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at the LSB.
    generate
        if (WIDTH == 1) begin : g_s1
            assign s_nxt = fa_s;
        end else begin : g_sn
            assign s_nxt = {fa_s, s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = RUN;
            RUN:     if (last)        state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
        busy         = (state == RUN) || (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            s_sh  <= s_nxt;
            carry <= fa_co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= s_nxt;
                cout <= fa_co;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last bit, carry is the carry into the MSB and fa_co the carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n)                   ovf <= 1'b0;
        else if (state == RUN && last) ovf <= carry ^ fa_co;
    end
`endif
endmodule
